ram_rmw_master: RTL and testbench
=================================

# ram_rmw_master

Request-side initiator for the word-wide dual-port RAM (`dual_ram`) used by the core testbench and data-memory path. It accepts byte-addressed load/store requests of byte, half or word size and drives the RAM's separate read and write ports. Sub-word stores are done as read-modify-write. Loads are returned zero- or sign-extended. Only one request is outstanding at a time, so the RAM never sees same-address read and write in one cycle from this block.

## Interface
- `DW`, 32, RAM word width; fixed at 32 for lane logic.
- `AW`, 12, RAM word-address width. Byte address bits `[AW+1:2]` select the word.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend load result.
- `req_addr` in 32: byte address. Bits above `AW+1` are ignored, so the address wraps.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: response accepted.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal-size request.
- `r_en` out 1, `r_addr_o` out AW: RAM read port.
- `r_data_i` in 32: RAM read data, valid one cycle after `r_en`.
- `w_en` out 1, `w_addr_o` out AW, `w_data_o` out 32: RAM write port.

## Operation
- States and transitions:
  - IDLE: on `req_valid && req_ready`, latch the request, then:
    - misaligned or size 11 → RESP with error;
    - word store → WR;
    - otherwise → RD.
  - RD: `r_en`=1, `r_addr_o`=word address → CAP.
  - CAP: capture `r_data_i`. Load → format, then RESP. Sub-word store → merge, then WR.
  - WR: `w_en`=1 with `w_addr_o` and the merged or full word → RESP.
  - RESP: `rsp_valid`=1; on `rsp_ready` → IDLE.
- Misaligned means: half with `addr[0]`=1, or word with `addr[1:0]`≠0. An error performs no RAM access.
- Load formatting:
  - byte lane = `addr[1:0]`, half lane = `addr[1]`;
  - extend from bit 7 or bit 15 when `req_signed`, else zero-extend;
  - word loads ignore `req_signed`.
- Store merge: replace only the addressed byte(s) of the read word with `req_wdata[7:0]` or `req_wdata[15:0]`; the other bytes are kept.
- `r_en`, `w_en` and the RAM addresses/data are decoded from registered state and latched fields only. There is no combinational path from `req_*` to the RAM ports.
- `rsp_rdata` and `rsp_err` are stable while `rsp_valid`=1.

## Timing
- Reset values:
  - state IDLE, so `req_ready`=1;
  - `rsp_valid`=0, `rsp_err`=0;
  - `rsp_rdata`, `r_en`, `w_en` = 0;
  - `r_addr_o`, `w_addr_o`, `w_data_o` = 0.
- Latency, with accept at cycle 0 and `rsp_ready` held high:
  - error: RESP in cycle 1;
  - word store: WR in cycle 1, RESP in cycle 2;
  - load: RD 1, CAP 2, RESP 3;
  - sub-word store: RD 1, CAP 2, WR 3, RESP 4.
- Throughput: the next accept is possible in the cycle after the RESP handshake.
- `rsp_ready` low: stay in RESP indefinitely, outputs unchanged.
- Reset asserted mid-operation: immediate return to IDLE. A pending WR is discarded and no `w_en` pulse is issued. `rsp_valid` drops.

## Structure
- Package `ram_rmw_pkg`: `req_size` encodings (SZ_B/SZ_H/SZ_W), state enum (IDLE/RD/CAP/WR/RESP).
- Sub-module `ram_lane_fmt` (combinational): load extract/extend and store byte-merge from size, `addr[1:0]`, signed, read word and write data.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10:
  - `w_en` in cycle 1 with `w_addr_o`=4;
  - load returns 0xDEADBEEF at cycle 3, `rsp_err`=0.
- RAM word 4 = 0x11223344; byte store 0xAA at 0x12:
  - RD then WR;
  - `w_data_o`=0x11AA3344 in cycle 3.
- RAM word 4 = 0x8000_7F00:
  - signed half load at 0x12 → 0xFFFF8000;
  - unsigned byte load at 0x11 → 0x0000007F.
- Half load at 0x13, then word store at 0x06:
  - each gives `rsp_err`=1 and `rsp_rdata`=0 in cycle 1;
  - `r_en` and `w_en` never assert.
- Load with `rsp_ready` low for 5 cycles:
  - `rsp_valid` and data held;
  - `req_ready`=0 throughout;
  - accept happens on the `rsp_ready` rise.
- Sub-word store with `rst` pulsed during CAP:
  - no `w_en` pulse, RAM word unchanged;
  - `req_ready`=1 after reset.

Source files
------------

// File: rtl/ram_rmw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_rmw_pkg
// Description : Shared encodings for the RAM read-modify-write master:
//               request size codes, controller states, request legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_rmw_pkg;

  // Request size encodings
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Controller states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // A request is rejected when the size code is illegal or the address is
  // not naturally aligned for the access size.
  function automatic logic req_is_bad(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : ram_lane_fmt
// Description : Combinational byte-lane logic. Extracts and extends load data
//               from a RAM word, and merges sub-word store data into a word.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_lane_fmt
  import ram_rmw_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane of the read word
  always_comb begin
    w_byte = rd_word[{addr_lo, 3'b000} +: 8];
    w_half = rd_word[{addr_lo[1], 4'b0000} +: 16];
  end

  // Extend the selected lane; word loads pass straight through
  always_comb begin
    load_data = rd_word;
    case (size)
      SZ_B:    load_data = {{24{sign_ext & w_byte[7]}}, w_byte};
      SZ_H:    load_data = {{16{sign_ext & w_half[15]}}, w_half};
      default: load_data = rd_word;
    endcase
  end

  // Overwrite only the addressed byte(s), keep the rest of the read word
  always_comb begin
    merge_data = rd_word;
    case (size)
      SZ_B:    merge_data[{addr_lo, 3'b000} +: 8]      = wr_data[7:0];
      SZ_H:    merge_data[{addr_lo[1], 4'b0000} +: 16] = wr_data[15:0];
      default: merge_data = wr_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ram_rmw_master.sv
`default_nettype none
// ============================================================================
// Module      : ram_rmw_master
// Description : Single-outstanding load/store initiator for a word-wide
//               dual-port RAM. Sub-word stores use read-modify-write; loads
//               are zero/sign extended. RAM ports decode from registered state
//               and latched request fields only.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rmw_master
  import ram_rmw_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  // request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  // response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  // RAM read port
  output logic          r_en,
  output logic [AW-1:0] r_addr_o,
  input  logic [DW-1:0] r_data_i,
  // RAM write port
  output logic          w_en,
  output logic [AW-1:0] w_addr_o,
  output logic [DW-1:0] w_data_o
);

  state_t        r_state;
  state_t        w_state_next;

  logic          r_we;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [AW+1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_accept;
  logic          w_bad;
  logic [31:0]   w_load_data;
  logic [31:0]   w_merge_data;
  logic          w_unused_addr;

  // Upper address bits wrap and are deliberately dropped
  assign w_unused_addr = ^req_addr[31:AW+2];

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_bad    = req_is_bad(req_size, req_addr[1:0]);

  // Lane extract/extend and store merge on the captured RAM word
  ram_lane_fmt u_lane_fmt (
    .size       (r_size),
    .addr_lo    (r_addr[1:0]),
    .sign_ext   (r_signed),
    .rd_word    (r_data_i),
    .wr_data    (r_wdata),
    .load_data  (w_load_data),
    .merge_data (w_merge_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_bad)                              w_state_next = RESP;
          else if (req_we && (req_size == SZ_W))  w_state_next = WR;
          else                                    w_state_next = RD;
        end
      end
      RD:      w_state_next = CAP;
      CAP:     w_state_next = r_we ? WR : RESP;
      WR:      w_state_next = RESP;
      RESP:    w_state_next = rsp_ready ? IDLE : RESP;
      default: w_state_next = IDLE;
    endcase
  end

  // Latch the request on accept; capture load result or merged word in CAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= SZ_B;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr[AW+1:0];
      r_wdata  <= req_wdata;
      r_rdata  <= '0;
      r_err    <= w_bad;
    end else if (r_state == CAP) begin
      if (r_we) begin
        r_wdata <= w_merge_data;
      end else begin
        r_rdata <= w_load_data;
      end
    end
  end

  // Port decode from registered state and latched fields
  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    r_en      = (r_state == RD);
    w_en      = (r_state == WR);
    r_addr_o  = r_addr[AW+1:2];
    w_addr_o  = r_addr[AW+1:2];
    w_data_o  = r_wdata;
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_rmw_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_rmw_master
// Description : Directed self-checking bench for ram_rmw_master with a
//               behavioural dual-port RAM and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rmw_master;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          r_en;
  logic [AW-1:0] r_addr_o;
  logic [DW-1:0] r_data_i;
  logic          w_en;
  logic [AW-1:0] w_addr_o;
  logic [DW-1:0] w_data_o;

  int checks   = 0;
  int failures = 0;
  int ren_cnt  = 0;
  int wen_cnt  = 0;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [32:0] sb_q [$];   // {err, rdata}

  ram_rmw_master #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .r_en       (r_en),
    .r_addr_o   (r_addr_o),
    .r_data_i   (r_data_i),
    .w_en       (w_en),
    .w_addr_o   (w_addr_o),
    .w_data_o   (w_data_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (r_en) r_data_i <= mem[r_addr_o];
    if (w_en) mem[w_addr_o] = w_data_o;
  end

  // RAM port activity counters
  always @(posedge clk) begin
    if (r_en) ren_cnt++;
    if (w_en) wen_cnt++;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, follow it to its response and handshake.
  // Cycle numbers count clock edges after the accepting edge.
  task automatic do_req(input string tag,
                        input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat, input int exp_rcyc, input int exp_wcyc,
                        input logic [AW-1:0] exp_word, input logic [31:0] exp_wdata,
                        input int hold);
    int cyc;
    int rcyc;
    int wcyc;
    bit got;
    logic [32:0] exp_rsp;
    logic [31:0] held_data;
    rcyc = 0;
    wcyc = 0;
    got  = 1'b0;
    check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    sb_q.push_back({exp_err, exp_data});
    rsp_ready  = (hold == 0);
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
    check({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
    for (cyc = 1; cyc <= 10; cyc++) begin
      if (r_en && rcyc == 0) begin
        rcyc = cyc;
        check({tag, "_r_addr"}, {20'd0, r_addr_o}, {20'd0, exp_word});
      end
      if (w_en && wcyc == 0) begin
        wcyc = cyc;
        check({tag, "_w_addr"}, {20'd0, w_addr_o}, {20'd0, exp_word});
        check({tag, "_w_data"}, w_data_o, exp_wdata);
      end
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_r_cycle"}, rcyc, exp_rcyc);
    check({tag, "_w_cycle"}, wcyc, exp_wcyc);
    check({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
    exp_rsp = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h0;
    check({tag, "_rdata"}, rsp_rdata, exp_rsp[31:0]);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_rsp[32]});
    held_data = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, held_data);
      check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int ren0;
    int wen0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    r_data_i   = '0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata,          32'd0);
    check("rst_r_en",      {31'd0, r_en},      32'd0);
    check("rst_w_en",      {31'd0, w_en},      32'd0);
    check("rst_r_addr",    {20'd0, r_addr_o},  32'd0);
    check("rst_w_addr",    {20'd0, w_addr_o},  32'd0);
    check("rst_w_data",    w_data_o,           32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store then word load
    do_req("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0,
           2, 0, 1, 12'd4, 32'hDEADBEEF, 0);
    check("st_w_mem", mem[4], 32'hDEADBEEF);
    do_req("ld_w", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0,
           3, 1, 0, 12'd4, 32'h0, 0);

    // Byte store read-modify-write
    mem[4] = 32'h11223344;
    do_req("st_b", 1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA, 32'h0, 1'b0,
           4, 1, 3, 12'd4, 32'h11AA3344, 0);
    check("st_b_mem", mem[4], 32'h11AA3344);

    // Load formatting
    mem[4] = 32'h80007F00;
    do_req("ld_hs", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8000, 1'b0,
           3, 1, 0, 12'd4, 32'h0, 0);
    do_req("ld_hu", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008000, 1'b0,
           3, 1, 0, 12'd4, 32'h0, 0);
    do_req("ld_bu", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0,
           3, 1, 0, 12'd4, 32'h0, 0);
    do_req("ld_bs", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0,
           3, 1, 0, 12'd4, 32'h0, 0);

    // Half store merge, then word load through a wrapped address
    do_req("st_h", 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, 32'h0, 1'b0,
           4, 1, 3, 12'd4, 32'h12347F00, 0);
    do_req("ld_wrap", 1'b0, 2'b10, 1'b0, 32'h4010, 32'h0, 32'h12347F00, 1'b0,
           3, 1, 0, 12'd4, 32'h0, 0);

    // Error requests perform no RAM access
    ren0 = ren_cnt;
    wen0 = wen_cnt;
    do_req("err_h", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h0, 1'b1,
           1, 0, 0, 12'd0, 32'h0, 0);
    do_req("err_w", 1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 32'h0, 1'b1,
           1, 0, 0, 12'd0, 32'h0, 0);
    do_req("err_sz", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1,
           1, 0, 0, 12'd0, 32'h0, 0);
    check("err_no_ren", ren_cnt, ren0);
    check("err_no_wen", wen_cnt, wen0);
    check("err_mem", mem[4], 32'h12347F00);

    // Response backpressure
    do_req("bp", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00007F00, 1'b0,
           3, 1, 0, 12'd4, 32'h0, 5);

    // Reset during CAP of a sub-word store
    mem[4] = 32'hCAFEF00D;
    wen0 = wen_cnt;
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h12;
    req_wdata  = 32'h77;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    check("rst_mid_rd", {31'd0, r_en}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_wen",   {31'd0, w_en},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_wen", wen_cnt, wen0);
    check("rst_mid_mem",    mem[4],  32'hCAFEF00D);
    check("rst_mid_idle",   {31'd0, req_ready}, 32'd1);

    // Normal operation after reset
    do_req("post_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0,
           3, 1, 0, 12'd4, 32'h0, 0);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
